hough_accumulator: RTL and testbench



---
 rtl/hough_pkg.sv | 33 +++
 rtl/hough_vote_ram.sv | 24 ++
 rtl/hough_accumulator.sv | 183 ++++++++++++++++++
 tb/tb_hough_accumulator.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// Shared types and helpers for the Hough accumulator stage.
// Holds the FSM state enum, default widths and rho <-> offset-binary mapping.
package hough_pkg;

  localparam int DEF_RHO_W   = 11;
  localparam int DEF_THETA_W = 8;
  localparam int DEF_COUNT_W = 10;
  localparam int CONV_W      = 32;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_ACCUM,
    ST_DRAIN,
    ST_SCAN,
    ST_REPORT
  } state_t;

  // Flipping the sign bit turns two's complement into offset binary.
  function automatic logic [CONV_W-1:0] rho_to_ofs(
    input logic [CONV_W-1:0] rho,
    input int                w
  );
    return rho ^ (CONV_W'(1) << (w - 1));
  endfunction

  function automatic logic [CONV_W-1:0] ofs_to_rho(
    input logic [CONV_W-1:0] ofs,
    input int                w
  );
    return ofs ^ (CONV_W'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/hough_vote_ram.sv
// Simple dual-port vote counter RAM.
// One-cycle registered read; a same-address read during a write sees old data.
module hough_vote_ram
  import hough_pkg::*;
#(
  parameter int AW = DEF_RHO_W + DEF_THETA_W,
  parameter int DW = DEF_COUNT_W
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hough_accumulator.sv
// Hough vote accumulator: counts votes per (rho, theta) bin, reports the peak.
// Optional macro HOUGH_ACC_THRESH_EN adds min_votes / peak_miss thresholding.
module hough_accumulator
  import hough_pkg::*;
#(
  parameter int RHO_W   = DEF_RHO_W,
  parameter int THETA_W = DEF_THETA_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               vote_valid,
  input  logic [RHO_W-1:0]   vote_rho,
  input  logic [THETA_W-1:0] vote_theta,
  input  logic               frame_end,
`ifdef HOUGH_ACC_THRESH_EN
  input  logic [COUNT_W-1:0] min_votes,
  output logic               peak_miss,
`endif
  output logic               vote_ready,
  output logic               drop_err,
  output logic               peak_valid,
  output logic [RHO_W-1:0]   peak_rho,
  output logic [THETA_W-1:0] peak_theta,
  output logic [COUNT_W-1:0] peak_count
);

  localparam int AW = RHO_W + THETA_W;
  localparam logic [AW:0]      CNT_ONE = 1;
  localparam logic [AW-1:0]    A_ONE   = 1;
  localparam logic [COUNT_W-1:0] C_ONE = 1;
  localparam logic [COUNT_W-1:0] C_MAX = '1;

  state_t state, state_nx;

  logic [AW:0]        cnt;
  logic               s1_valid;
  logic [AW-1:0]      s1_addr;
  logic               s2_valid;
  logic [AW-1:0]      s2_addr;
  logic [COUNT_W-1:0] s2_data;
  logic [COUNT_W-1:0] max_cnt;
  logic [AW-1:0]      max_idx;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [AW-1:0]      raddr;
  logic [COUNT_W-1:0] wdata;
  logic [COUNT_W-1:0] rdata;
  logic [COUNT_W-1:0] base;
  logic [COUNT_W-1:0] inc;
  logic [AW-1:0]      vote_addr;
  logic [AW-1:0]      scan_idx;
  logic               take;
  logic               scan_last;
  logic [COUNT_W-1:0] fin_cnt;
  logic [AW-1:0]      fin_idx;
  logic [CONV_W-1:0]  ofs_full;
  logic [CONV_W-1:0]  rho_full;
  logic               unused_hi;

  assign ofs_full  = rho_to_ofs(CONV_W'(vote_rho), RHO_W);
  assign rho_full  = ofs_to_rho(CONV_W'(fin_idx[RHO_W-1:0]), RHO_W);
  assign unused_hi = ^{ofs_full[CONV_W-1:RHO_W], rho_full[CONV_W-1:RHO_W]};

  assign vote_ready = (state == ST_ACCUM);
  assign take       = vote_valid & vote_ready;
  assign vote_addr  = {vote_theta, ofs_full[RHO_W-1:0]};

  // Forward last cycle's write: the RAM read issued then saw the old value.
  assign base = (s2_valid && s2_addr == s1_addr) ? s2_data : rdata;
  assign inc  = (base == C_MAX) ? base : base + C_ONE;

  assign scan_idx  = cnt[AW-1:0] - A_ONE;
  assign scan_last = (state == ST_SCAN) && cnt[AW];

  always_comb begin
    fin_cnt = max_cnt;
    fin_idx = max_idx;
    if (cnt == CNT_ONE || rdata > max_cnt) begin
      fin_cnt = rdata;
      fin_idx = scan_idx;
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = s1_addr;
    wdata = inc;
    raddr = vote_addr;
    if (state == ST_CLEAR) begin
      we    = 1'b1;
      waddr = cnt[AW-1:0];
      wdata = '0;
    end else if (s1_valid) begin
      we = 1'b1;
    end
    if (state == ST_SCAN) raddr = cnt[AW-1:0];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_CLEAR:  if (&cnt[AW-1:0]) state_nx = ST_ACCUM;
      ST_ACCUM:  if (frame_end) state_nx = ST_DRAIN;
      ST_DRAIN:  state_nx = ST_SCAN;
      ST_SCAN:   if (cnt[AW]) state_nx = ST_REPORT;
      ST_REPORT: state_nx = ST_CLEAR;
      default:   state_nx = ST_CLEAR;
    endcase
  end

  hough_vote_ram #(
    .AW (AW),
    .DW (COUNT_W)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_addr    <= '0;
      s2_data    <= '0;
      max_cnt    <= '0;
      max_idx    <= '0;
      drop_err   <= 1'b0;
      peak_valid <= 1'b0;
      peak_rho   <= '0;
      peak_theta <= '0;
      peak_count <= '0;
`ifdef HOUGH_ACC_THRESH_EN
      peak_miss  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      s1_valid <= take;
      s1_addr  <= vote_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= inc;
      if (vote_valid && !vote_ready) drop_err <= 1'b1;

      unique case (state)
        ST_CLEAR: cnt <= (&cnt[AW-1:0]) ? '0 : cnt + CNT_ONE;
        ST_SCAN: begin
          cnt <= cnt[AW] ? '0 : cnt + CNT_ONE;
          if (cnt != '0) begin
            max_cnt <= fin_cnt;
            max_idx <= fin_idx;
          end
        end
        default: cnt <= '0;
      endcase

      peak_valid <= 1'b0;
`ifdef HOUGH_ACC_THRESH_EN
      peak_miss  <= 1'b0;
`endif
      if (scan_last) begin
        peak_rho   <= rho_full[RHO_W-1:0];
        peak_theta <= fin_idx[AW-1:RHO_W];
        peak_count <= fin_cnt;
`ifdef HOUGH_ACC_THRESH_EN
        peak_valid <= (fin_cnt >= min_votes);
        peak_miss  <= (fin_cnt < min_votes);
`else
        peak_valid <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hough_accumulator.sv
// Self-checking bench for hough_accumulator (RHO_W=4, THETA_W=2, COUNT_W=4).
// Directed frame table, corner sequences and random frames vs a bin-count model.
module tb_hough_accumulator;

  localparam int NB   = 64;
  localparam int LAT  = 67;
  localparam int CSAT = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       vote_valid;
  logic [3:0] vote_rho;
  logic [1:0] vote_theta;
  logic       frame_end;
  logic       vote_ready;
  logic       drop_err;
  logic       peak_valid;
  logic [3:0] peak_rho;
  logic [1:0] peak_theta;
  logic [3:0] peak_count;
  logic       pmiss;
`ifdef HOUGH_ACC_THRESH_EN
  logic [3:0] min_votes;
  logic       peak_miss;
  assign pmiss = peak_miss;
`else
  assign pmiss = 1'b0;
`endif

  always #5 clock = ~clock;

  hough_accumulator #(
    .RHO_W   (4),
    .THETA_W (2),
    .COUNT_W (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .vote_valid (vote_valid),
    .vote_rho   (vote_rho),
    .vote_theta (vote_theta),
    .frame_end  (frame_end),
`ifdef HOUGH_ACC_THRESH_EN
    .min_votes  (min_votes),
    .peak_miss  (peak_miss),
`endif
    .vote_ready (vote_ready),
    .drop_err   (drop_err),
    .peak_valid (peak_valid),
    .peak_rho   (peak_rho),
    .peak_theta (peak_theta),
    .peak_count (peak_count)
  );

  typedef struct {
    int rho;
    int theta;
    int gap;
  } vote_t;

  typedef struct {
    int r1, t1, n1;
    int r2, t2, n2;
    int er, et, ec;
  } vec_t;

  vote_t vq[$];
  vec_t  tbl[6];
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic push(input int rho, input int theta, input int n);
    for (int i = 0; i < n; i++) vq.push_back('{rho, theta, 0});
  endtask

  // Reference: count votes per (rho, theta) bin, saturate, pick first maximum.
  task automatic model_peak(output int er, output int et, output int ec);
    int b[NB];
    int best;
    int bi;
    foreach (b[i]) b[i] = 0;
    foreach (vq[i]) begin
      bi = vq[i].theta * 16 + (vq[i].rho + 8);
      if (b[bi] < CSAT) b[bi]++;
    end
    best = 0;
    for (int i = 1; i < NB; i++) if (b[i] > b[best]) best = i;
    er = (best % 16) - 8;
    et = best / 16;
    ec = b[best];
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    vote_valid = 1'b0;
    frame_end = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_ready();
    int ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (vote_ready) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  // Drives vq one vote per cycle (plus gaps), then frame_end; waits for report.
  task automatic play(input bit fe_last, input int inj,
                      output int lat, output bit gv, output bit gm,
                      output int pr, output int pt, output int pc);
    int n;
    n = vq.size();
    lat = 0; gv = 0; gm = 0; pr = 0; pt = 0; pc = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < vq[i].gap; g++) begin
        @(negedge clock);
        vote_valid = 1'b0;
        frame_end = 1'b0;
      end
      @(negedge clock);
      vote_valid = 1'b1;
      vote_rho   = 4'(vq[i].rho);
      vote_theta = 2'(vq[i].theta);
      frame_end  = fe_last && (i == n - 1);
    end
    if (!(fe_last && n > 0)) begin
      @(negedge clock);
      vote_valid = 1'b0;
      frame_end = 1'b1;
    end
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      frame_end  = 1'b0;
      vote_valid = (k == inj);
      vote_rho   = 4'd6;
      vote_theta = 2'd3;
      if (peak_valid || pmiss) begin
        lat = k;
        gv = peak_valid;
        gm = pmiss;
        pr = int'($signed(peak_rho));
        pt = int'(peak_theta);
        pc = int'(peak_count);
        break;
      end
    end
    vote_valid = 1'b0;
    if (lat == 0) chk("report_timeout", 0, 1);
  endtask

  initial begin
    int lat, pr, pt, pc, er, et, ec, rdy, bad;
    bit gv, gm;
    int pool_r[3];
    int pool_t[3];
    int nv;

    reset = 1'b0;
    vote_valid = 1'b0;
    vote_rho = '0;
    vote_theta = '0;
    frame_end = 1'b0;
`ifdef HOUGH_ACC_THRESH_EN
    min_votes = '0;
`endif

    tbl[0] = '{-3, 2, 3,  0, 0, 0, -3, 2, 3};
    tbl[1] = '{ 5, 1, 20, 0, 0, 1,  5, 1, 15};
    tbl[2] = '{ 1, 0, 2,  1, 3, 2,  1, 0, 2};
    tbl[3] = '{ 0, 0, 0,  0, 0, 0, -8, 0, 0};
    tbl[4] = '{ 7, 3, 1, -8, 0, 1, -8, 0, 1};
    tbl[5] = '{-1, 2, 4,  2, 2, 5,  2, 2, 5};

    // Power-up clear: exact length, outputs quiet.
    do_reset();
    rdy = 0;
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (vote_ready) begin
        rdy = k;
        break;
      end
      if (peak_valid || peak_rho != 0 || peak_theta != 0 ||
          peak_count != 0 || drop_err) bad = 1;
    end
    chk("clear_len", rdy, 64);
    chk("clear_quiet", bad, 0);

    // Directed frame table.
    foreach (tbl[i]) begin
      vq.delete();
      push(tbl[i].r1, tbl[i].t1, tbl[i].n1);
      push(tbl[i].r2, tbl[i].t2, tbl[i].n2);
      wait_ready();
      play(i % 2 == 1, 0, lat, gv, gm, pr, pt, pc);
      chk($sformatf("tbl%0d_valid", i), int'(gv), 1);
      chk($sformatf("tbl%0d_lat", i), lat, LAT);
      chk($sformatf("tbl%0d_rho", i), pr, tbl[i].er);
      chk($sformatf("tbl%0d_theta", i), pt, tbl[i].et);
      chk($sformatf("tbl%0d_count", i), pc, tbl[i].ec);
      if (i == 0) chk("first_vote_to_peak", vq.size() + lat, 70);
    end
    chk("no_drop_normal", int'(drop_err), 0);

    // Random frames against the bin-count model.
    for (int f = 0; f < 6; f++) begin
      vq.delete();
      for (int p = 0; p < 3; p++) begin
        pool_r[p] = int'($urandom_range(0, 15)) - 8;
        pool_t[p] = int'($urandom_range(0, 3));
      end
      nv = int'($urandom_range(1, 40));
      for (int v = 0; v < nv; v++) begin
        int s;
        s = int'($urandom_range(0, 2));
        vq.push_back('{pool_r[s], pool_t[s], int'($urandom_range(0, 2))});
      end
      model_peak(er, et, ec);
      wait_ready();
      play(1'($urandom_range(0, 1)), 0, lat, gv, gm, pr, pt, pc);
      chk($sformatf("rnd%0d_lat", f), lat, LAT);
      chk($sformatf("rnd%0d_rho", f), pr, er);
      chk($sformatf("rnd%0d_theta", f), pt, et);
      chk($sformatf("rnd%0d_count", f), pc, ec);
    end

    // Vote during CLEAR is dropped and flagged.
    @(negedge clock);
    @(negedge clock);
    vote_valid = 1'b1;
    vote_rho = 4'd6;
    vote_theta = 2'd3;
    @(negedge clock);
    vote_valid = 1'b0;
    chk("drop_in_clear", int'(drop_err), 1);
    vq.delete();
    push(6, 3, 1);
    wait_ready();
    play(1'b1, 0, lat, gv, gm, pr, pt, pc);
    chk("after_clear_drop_count", pc, 1);
    chk("after_clear_drop_rho", pr, 6);

    // Reset returns registered outputs and drop_err to zero.
    do_reset();
    @(negedge clock);
    chk("rst_drop_err", int'(drop_err), 0);
    chk("rst_peak_rho", int'(peak_rho), 0);
    chk("rst_peak_theta", int'(peak_theta), 0);
    chk("rst_peak_count", int'(peak_count), 0);
    chk("rst_ready", int'(vote_ready), 0);

    // Vote during SCAN is dropped and flagged.
    wait_ready();
    vq.delete();
    push(-4, 1, 2);
    play(1'b0, 10, lat, gv, gm, pr, pt, pc);
    chk("drop_in_scan", int'(drop_err), 1);
    chk("scan_drop_count", pc, 2);
    vq.delete();
    push(6, 3, 1);
    wait_ready();
    play(1'b1, 0, lat, gv, gm, pr, pt, pc);
    chk("after_scan_drop_count", pc, 1);

    // Reset in the middle of SCAN: no report, fresh clear.
    wait_ready();
    @(negedge clock);
    vote_valid = 1'b1;
    vote_rho = 4'd2;
    vote_theta = 2'd1;
    frame_end = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      vote_valid = 1'b0;
      frame_end = 1'b0;
    end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    rdy = 0;
    bad = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      if (peak_valid) bad = 1;
      if (vote_ready && rdy == 0) rdy = k;
    end
    chk("rst_scan_no_peak", bad, 0);
    chk("rst_scan_clear_len", rdy, 64);

`ifdef HOUGH_ACC_THRESH_EN
    // Threshold: max bin below min_votes gives a miss pulse instead.
    min_votes = 4'd4;
    vq.delete();
    push(-3, 2, 3);
    wait_ready();
    play(1'b0, 0, lat, gv, gm, pr, pt, pc);
    chk("thr_miss", int'(gm), 1);
    chk("thr_no_valid", int'(gv), 0);
    chk("thr_miss_lat", lat, LAT);
    min_votes = 4'd3;
    wait_ready();
    play(1'b0, 0, lat, gv, gm, pr, pt, pc);
    chk("thr_hit_valid", int'(gv), 1);
    chk("thr_hit_no_miss", int'(gm), 0);
    chk("thr_hit_count", pc, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
